// File: rtl/rip_ro_freq_counter.sv
// Ring-oscillator frequency counter.
// Counts synchronised rising edges of ro_in over a programmable window of clk
// cycles and publishes the (saturating) count once per measurement.
module rip_ro_freq_counter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             valid
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ro_s;
    logic                   prev_q;
    logic                   edge_det;

    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] rem_q;
    logic [CNT_W-1:0] acc_q;
    logic             sat_q;

    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             valid_q;

    // Synchroniser chain for the asynchronous oscillator input; only the last stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
        end
    end

    assign ro_s     = sync_q[SYNC_STAGES-1];
    assign edge_det = ro_s & ~prev_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ARM skips straight to DONE for a zero-length window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                state_d = (win_q != '0) ? StMeasure : StDone;
            end
            StMeasure: begin
                if (rem_q == WIN_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Measurement datapath: window latch, cycle countdown, saturating edge accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            win_q  <= '0;
            rem_q  <= '0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            // prev tracks ro_s every cycle, so it already equals ro_s when ARM ends.
            prev_q <= ro_s;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        win_q <= window_len;
                    end
                end
                StArm: begin
                    acc_q <= '0;
                    sat_q <= 1'b0;
                    rem_q <= win_q;
                end
                StMeasure: begin
                    rem_q <= rem_q - WIN_W'(1);
                    if (edge_det) begin
                        if (acc_q == {CNT_W{1'b1}}) begin
                            sat_q <= 1'b1;
                        end else begin
                            acc_q <= acc_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: only touched in the DONE cycle so they hold across measurements.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else if (state_q == StDone) begin
            count_q    <= acc_q;
            overflow_q <= sat_q;
            valid_q    <= 1'b1;
        end
    end

    assign busy     = (state_q == StArm) || (state_q == StMeasure);
    assign done     = (state_q == StDone);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_rip_ro_freq_counter.sv
// Self-checking bench for rip_ro_freq_counter: a default-width instance and a
// 4-bit-count instance share stimulus; expected results come from counting
// rising edges in a recorded history of ro_in.
module tb_rip_ro_freq_counter;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ro_in = 1'b0;
    logic        start = 1'b0;
    logic [15:0] window_len = '0;

    logic        busy, done, overflow, valid;
    logic [15:0] count;
    logic        busy4, done4, overflow4, valid4;
    logic [3:0]  count4;

    rip_ro_freq_counter #(.SYNC_STAGES(SYNC), .WIN_W(16), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ro_in      (ro_in),
        .start      (start),
        .window_len (window_len),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .overflow   (overflow),
        .valid      (valid)
    );

    rip_ro_freq_counter #(.SYNC_STAGES(SYNC), .WIN_W(16), .CNT_W(4)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .ro_in      (ro_in),
        .start      (start),
        .window_len (window_len),
        .busy       (busy4),
        .done       (done4),
        .count      (count4),
        .overflow   (overflow4),
        .valid      (valid4)
    );

    always #5 clk = ~clk;

    // Cycle index: value k while inside clock cycle k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ro_in value held during each cycle (sampled at that cycle's closing edge).
    bit ro_hist[int];
    int ro_half = 0;  // 0: random per cycle, otherwise toggle every ro_half cycles

    initial begin : ro_drv
        int ph;
        bit v;
        ph = 0;
        v  = 1'b0;
        forever begin
            @(negedge clk);
            if (ro_half == 0) begin
                v = 1'($urandom_range(0, 1));
            end else begin
                ph++;
                if (ph >= ro_half) begin
                    ph = 0;
                    v  = ~v;
                end
            end
            ro_in       = v;
            ro_hist[cyc] = v;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    int exp_cnt16 = 0;
    int exp_cnt4  = 0;
    bit exp_ov16  = 1'b0;
    bit exp_ov4   = 1'b0;
    bit exp_valid = 1'b0;

    function automatic bit hist(input int i);
        if (ro_hist.exists(i)) return ro_hist[i];
        return 1'b0;
    endfunction

    // The synchronised signal in cycle k is ro_in from cycle k-SYNC; the measuring
    // cycles of a start accepted in cycle t are t+2 .. t+1+n.
    function automatic int edges_in(input int t, input int n);
        int e;
        e = 0;
        for (int k = t + 2; k <= t + 1 + n; k++) begin
            if (hist(k - SYNC) && !hist(k - SYNC - 1)) e++;
        end
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One complete measurement of n cycles, checked cycle by cycle. If repulse_at > 0,
    // start is re-pulsed with window_len=repulse_len in cycle t+repulse_at.
    task automatic run_measure(input int n, input int repulse_at, input int repulse_len);
        int t;
        int e;
        start      = 1'b1;
        window_len = n[15:0];
        t          = cyc;
        step();
        start      = 1'b0;
        window_len = 16'($urandom);
        for (int c = 1; c <= n + 2; c++) begin
            n_checks++;
            if (busy !== (c <= n + 1)) begin
                n_fail++;
                $display("FAIL busy t+%0d (n=%0d): got %b want %b", c, n, busy, (c <= n + 1));
            end
            n_checks++;
            if (done !== (c == n + 2)) begin
                n_fail++;
                $display("FAIL done t+%0d (n=%0d): got %b want %b", c, n, done, (c == n + 2));
            end
            n_checks++;
            if (done4 !== (c == n + 2)) begin
                n_fail++;
                $display("FAIL done4 t+%0d (n=%0d): got %b want %b", c, n, done4, (c == n + 2));
            end
            n_checks++;
            if (count !== exp_cnt16[15:0] || overflow !== exp_ov16) begin
                n_fail++;
                $display("FAIL hold t+%0d: got count=%0d ov=%b want count=%0d ov=%b",
                         c, count, overflow, exp_cnt16, exp_ov16);
            end
            start = (c == repulse_at);
            if (c == repulse_at) window_len = repulse_len[15:0];
            step();
        end
        start = 1'b0;
        e         = edges_in(t, n);
        exp_cnt16 = (e > 65535) ? 65535 : e;
        exp_ov16  = (e > 65535);
        exp_cnt4  = (e > 15) ? 15 : e;
        exp_ov4   = (e > 15);
        exp_valid = 1'b1;
        n_checks++;
        if (count !== exp_cnt16[15:0] || overflow !== exp_ov16 || valid !== exp_valid) begin
            n_fail++;
            $display("FAIL result n=%0d: got count=%0d ov=%b valid=%b want count=%0d ov=%b valid=1",
                     n, count, overflow, valid, exp_cnt16, exp_ov16);
        end
        n_checks++;
        if (count4 !== exp_cnt4[3:0] || overflow4 !== exp_ov4 || valid4 !== 1'b1) begin
            n_fail++;
            $display("FAIL result4 n=%0d: got count=%0d ov=%b valid=%b want count=%0d ov=%b valid=1",
                     n, count4, overflow4, valid4, exp_cnt4, exp_ov4);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_idle n=%0d: got busy=%b done=%b want 0 0", n, busy, done);
        end
    endtask

    task automatic test_reset();
        ro_half    = 0;
        rst        = 1'b1;
        start      = 1'b1;
        window_len = 16'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({busy, done, count, overflow, valid} !== '0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got busy=%b done=%b count=%0d ov=%b valid=%b want all 0",
                         i, busy, done, count, overflow, valid);
            end
            n_checks++;
            if ({busy4, done4, count4, overflow4, valid4} !== '0) begin
                n_fail++;
                $display("FAIL reset4 cyc %0d: got busy=%b done=%b count=%0d ov=%b valid=%b want all 0",
                         i, busy4, done4, count4, overflow4, valid4);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b valid=%b want 0 0", busy, valid);
        end
        idle_cycles(5);
    endtask

    task automatic test_basic();
        ro_half = 5;
        idle_cycles(12);
        run_measure(100, 0, 0);
        n_checks++;
        if (count !== 16'd10 || overflow !== 1'b0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic: got count=%0d ov=%b valid=%b want 10 0 1", count, overflow, valid);
        end
    endtask

    task automatic test_saturation();
        ro_half = 1;
        idle_cycles(4);
        run_measure(40, 0, 0);
        n_checks++;
        if (count4 !== 4'd15 || overflow4 !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation: got count=%0d ov=%b want 15 1", count4, overflow4);
        end
        n_checks++;
        if (count !== 16'd20 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_no_sat: got count=%0d ov=%b want 20 0", count, overflow);
        end
    endtask

    task automatic test_zero_window();
        ro_half = 0;
        idle_cycles(3);
        run_measure(0, 0, 0);
        n_checks++;
        if (count !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_window: got count=%0d ov=%b want 0 0", count, overflow);
        end
    endtask

    task automatic test_ignored_start();
        ro_half = 3;
        idle_cycles(3);
        // Re-pulse during MEASURE: no queued second measurement.
        run_measure(50, 10, 5);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL ignored_start +%0d: got busy=%b done=%b want 0 0", i, busy, done);
            end
            step();
        end
        // Re-pulse in the DONE cycle is also dropped.
        run_measure(5, 7, 9);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL start_in_done +%0d: got busy=%b done=%b want 0 0", i, busy, done);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            ro_half = $urandom_range(0, 4);
            run_measure($urandom_range(1, 60), 0, 0);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        ro_half = 5;
        idle_cycles(12);
        run_measure(70, 0, 0);
        n_checks++;
        if (count !== 16'd7) begin
            n_fail++;
            $display("FAIL pre_abort_count: got %0d want 7", count);
        end
        start      = 1'b1;
        window_len = 16'd100;
        t          = cyc;
        step();
        start = 1'b0;
        while (cyc < t + 20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, count, overflow, valid} !== '0) begin
            n_fail++;
            $display("FAIL abort: got busy=%b done=%b count=%0d ov=%b valid=%b want all 0",
                     busy, done, count, overflow, valid);
        end
        exp_cnt16 = 0;
        exp_cnt4  = 0;
        exp_ov16  = 1'b0;
        exp_ov4   = 1'b0;
        exp_valid = 1'b0;
        for (int i = 0; i < 110; i++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_idle +%0d: got busy=%b done=%b valid=%b want 0 0 0",
                         i, busy, done, valid);
            end
        end
        ro_half = 0;
        run_measure($urandom_range(1, 30), 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_zero_window();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
